// File: rtl/sobel_window_gen_pkg.sv
// Shared constants and helpers for the Sobel 3x3 window generator.
// Pixel width, window byte layout and counter-width helper.
package sobel_window_gen_pkg;

    localparam int PIX_W      = 8;
    localparam int WIN_N      = 9;
    localparam int WIN_W      = PIX_W * WIN_N;
    localparam int CENTRE_IDX = 4;

    typedef logic [PIX_W-1:0] pix_t;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle for the Sobel window generator.
// master drives pixels and consumes windows; slave is the generator.
interface sobel_window_gen_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    import sobel_window_gen_pkg::*;

    logic             in_valid;
    logic             in_ready;
    pix_t             in_pixel;
    logic             in_sof;
    logic             win_valid;
    logic             win_ready;
    logic [WIN_W-1:0] win_data;
    logic [XW-1:0]    win_x;
    logic [YW-1:0]    win_y;
    logic             frame_done;
    logic             frame_err;

    modport master (
        output in_valid, in_pixel, in_sof, win_ready,
        input  in_ready, win_valid, win_data, win_x, win_y,
        input  frame_done, frame_err
    );

    modport slave (
        input  in_valid, in_pixel, in_sof, win_ready,
        output in_ready, win_valid, win_data, win_x, win_y,
        output frame_done, frame_err
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of pixels: combinational read, clocked write, shared address.
// Contents are not reset; every location is written before it is read.
module sobel_line_buffer
    import sobel_window_gen_pkg::*;
#(
    parameter int WIDTH = 640,
    parameter int AW    = cnt_w(WIDTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          rdata
);

    pix_t mem [WIDTH];

    // Row storage write port
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel stage.
// Two line buffers plus a column shift register yield one window per interior pixel.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int WIDTH = 640,
    parameter int DEPTH = 480
) (
    input logic               clk,
    input logic               rst_n,
    sobel_window_gen_if.slave bus
);

    localparam int XW = cnt_w(WIDTH);
    localparam int YW = cnt_w(DEPTH);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(DEPTH - 1);

    logic [XW-1:0] x, cx, nx;
    logic [YW-1:0] y, cy, ny;
    logic          acc;
    logic          emit;
    logic          last;
    pix_t          lb0_rd;
    pix_t          lb1_rd;
    pix_t          new_col [3];
    pix_t          sr_a [3];
    pix_t          sr_b [3];
    logic [WIN_W-1:0] win_next;

    assign bus.in_ready = !bus.win_valid || bus.win_ready;
    assign acc  = bus.in_valid && bus.in_ready;
    assign cx   = bus.in_sof ? '0 : x;
    assign cy   = bus.in_sof ? '0 : y;
    assign emit = (cx >= XW'(2)) && (cy >= YW'(2));
    assign last = (cx == X_LAST) && (cy == Y_LAST);

    sobel_line_buffer #(.WIDTH(WIDTH), .AW(XW)) lb0 (
        .clk   (clk),
        .we    (acc),
        .addr  (cx),
        .wdata (bus.in_pixel),
        .rdata (lb0_rd)
    );

    sobel_line_buffer #(.WIDTH(WIDTH), .AW(XW)) lb1 (
        .clk   (clk),
        .we    (acc),
        .addr  (cx),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Next raster position and assembled window for the current pixel
    always_comb begin
        nx = cx + XW'(1);
        ny = cy;
        if (cx == X_LAST) begin
            nx = '0;
            ny = (cy == Y_LAST) ? '0 : cy + YW'(1);
        end
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = bus.in_pixel;
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            win_next[PIX_W*(3*r+0) +: PIX_W] = sr_a[r];
            win_next[PIX_W*(3*r+1) +: PIX_W] = sr_b[r];
            win_next[PIX_W*(3*r+2) +: PIX_W] = new_col[r];
        end
    end

    // Position counters, column shift register and frame status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x              <= '0;
            y              <= '0;
            sr_a           <= '{default: '0};
            sr_b           <= '{default: '0};
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.frame_err  <= 1'b0;
            if (acc) begin
                x              <= nx;
                y              <= ny;
                sr_a           <= sr_b;
                sr_b           <= new_col;
                bus.frame_done <= last;
                bus.frame_err  <= bus.in_sof && ((x != '0) || (y != '0));
            end
        end
    end

    // Registered window output with hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_valid <= 1'b0;
            bus.win_data  <= '0;
            bus.win_x     <= '0;
            bus.win_y     <= '0;
        end else if (acc && emit) begin
            bus.win_valid <= 1'b1;
            bus.win_data  <= win_next;
            bus.win_x     <= cx - XW'(1);
            bus.win_y     <= cy - YW'(1);
        end else if (bus.win_ready) begin
            bus.win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image, pixel = 16*y + x.
// Windows are collected by a monitor and compared against expected centres.
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int D  = 4;
    localparam int XW = 3;
    localparam int YW = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    logic [71:0] q_d [$];
    int          q_x [$];
    int          q_y [$];
    int          done_cnt;
    int          err_cnt;

    sobel_window_gen_if #(.XW(XW), .YW(YW)) bus ();

    sobel_window_gen #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        done_cnt = 0;
        err_cnt  = 0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.win_valid && bus.win_ready) begin
                q_d.push_back(bus.win_data);
                q_x.push_back(int'(bus.win_x));
                q_y.push_back(int'(bus.win_y));
            end
            if (bus.frame_done) done_cnt++;
            if (bus.frame_err) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int cx, input int cy);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*r+c) +: 8] = 8'(16*(cy-1+r) + (cx-1+c));
        return w;
    endfunction

    task automatic send(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        bus.in_sof   = sof;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("send_timeout", 72'd0, 72'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic stream_frame(input int npix, input bit gaps,
                                input bit stall, input bit exp_err);
        int px, py;
        for (int i = 0; i < npix; i++) begin
            px = i % W;
            py = i / W;
            send(8'(16*py + px), i == 0);
            if (i == 0) chk("frame_err", 72'(bus.frame_err), 72'(exp_err));
            if (i == 12) begin
                chk("first_valid", 72'(bus.win_valid), 72'd1);
                chk("first_data", bus.win_data, exp_win(1, 1));
                chk("first_x", 72'(bus.win_x), 72'd1);
                chk("first_y", 72'(bus.win_y), 72'd1);
                if (stall) begin
                    bus.win_ready = 1'b0;
                    bus.in_valid  = 1'b1;
                    bus.in_pixel  = 8'h23;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("stall_ready", 72'(bus.in_ready), 72'd0);
                        chk("stall_data", bus.win_data, exp_win(1, 1));
                        @(posedge clk);
                        #1;
                    end
                    bus.win_ready = 1'b1;
                end
            end
            if (i == W*D-1) chk("frame_done", 72'(bus.frame_done), 72'd1);
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input int qb, input int db,
                               input int eb, input int exp_err);
        chk({tag, "_nwin"}, 72'(q_d.size() - qb), 72'd6);
        for (int i = 0; i < 6; i++) begin
            if (qb + i < q_d.size()) begin
                chk({tag, "_data"}, q_d[qb+i], exp_win(1 + i%3, 1 + i/3));
                chk({tag, "_x"}, 72'(q_x[qb+i]), 72'(1 + i%3));
                chk({tag, "_y"}, 72'(q_y[qb+i]), 72'(1 + i/3));
            end
        end
        chk({tag, "_ndone"}, 72'(done_cnt - db), 72'd1);
        chk({tag, "_nerr"}, 72'(err_cnt - eb), 72'(exp_err));
    endtask

    initial begin
        int qb, db, eb;
        n_chk         = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_sof    = 1'b0;
        bus.win_ready = 1'b1;
        #3;
        chk("rst_valid", 72'(bus.win_valid), 72'd0);
        chk("rst_data", bus.win_data, 72'd0);
        chk("rst_x", 72'(bus.win_x), 72'd0);
        chk("rst_y", 72'(bus.win_y), 72'd0);
        chk("rst_done", 72'(bus.frame_done), 72'd0);
        chk("rst_err", 72'(bus.frame_err), 72'd0);
        chk("rst_ready", 72'(bus.in_ready), 72'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        qb = q_d.size(); db = done_cnt; eb = err_cnt;
        stream_frame(W*D, 0, 0, 0);
        check_frame("f1", qb, db, eb, 0);

        qb = q_d.size(); db = done_cnt; eb = err_cnt;
        stream_frame(W*D, 0, 0, 0);
        check_frame("f2", qb, db, eb, 0);

        qb = q_d.size(); db = done_cnt; eb = err_cnt;
        stream_frame(W*D, 1, 0, 0);
        check_frame("gaps", qb, db, eb, 0);

        qb = q_d.size(); db = done_cnt; eb = err_cnt;
        stream_frame(W*D, 0, 1, 0);
        check_frame("stall", qb, db, eb, 0);

        stream_frame(8, 0, 0, 0);
        chk("err_nowin", 72'(q_d.size() - qb), 72'd6);
        qb = q_d.size(); db = done_cnt; eb = err_cnt;
        stream_frame(W*D, 0, 0, 1);
        check_frame("err", qb, db, eb, 1);

        stream_frame(13, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 72'(bus.win_valid), 72'd0);
        chk("mid_rst_data", bus.win_data, 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qb = q_d.size(); db = done_cnt; eb = err_cnt;
        stream_frame(W*D, 0, 0, 0);
        check_frame("rst", qb, db, eb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
